// File: rtl/timer_seq_ctl_pkg.sv
// Shared constants for the MM:SS timer sequencer: state codes, digit indices, BCD digit limits.
package timer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SET   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] DIG_M1 = 2'd3;
  localparam logic [1:0] DIG_M0 = 2'd2;
  localparam logic [1:0] DIG_S1 = 2'd1;
  localparam logic [1:0] DIG_S0 = 2'd0;

  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [3:0] UNITS_MAX = 4'd9;

  function automatic logic [3:0] digit_max(input logic [1:0] dig);
    logic [3:0] lim;
    lim = UNITS_MAX;
    case (dig)
      DIG_M1, DIG_S1: lim = TENS_MAX;
      DIG_M0, DIG_S0: lim = UNITS_MAX;
      default:        lim = UNITS_MAX;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/timer_seq_ctl_bcd_digit_inc.sv
// Single BCD digit +1 that wraps to 0 once the digit reaches its limit.
module bcd_digit_inc (
  input  logic [3:0] i_digit,
  input  logic [3:0] i_max,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= i_max) ? 4'd0 : i_digit + 4'd1;

endmodule

// File: rtl/timer_seq_ctl.sv
// Mode sequencer for the MM:SS BCD up-counter: buttons -> counter controls, target edit, DONE/alarm.
// Optional macro ALARM_BLINK_EN: alarm toggles on each sec_tick in DONE instead of holding steady.
module timer_seq_ctl #(
  parameter int unsigned DONE_HOLD_S = 5,
  parameter logic [15:0] TARGET_RST  = 16'h0100
) (
  input  logic        clk,
  input  logic        init_rst,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_set,
  input  logic        btn_inc,
  input  logic        sec_tick,
  input  logic [15:0] times,
  input  logic [15:0] time_out,
  output logic        tmr_rst,
  output logic        tmr_stop,
  output logic        tmr_setting,
  output logic [15:0] target,
  output logic [1:0]  set_digit,
  output logic [2:0]  state,
  output logic        alarm
);
  import timer_pkg::*;

  localparam int unsigned HW = (DONE_HOLD_S > 1) ? $clog2(DONE_HOLD_S) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((DONE_HOLD_S == 0) ? 0 : DONE_HOLD_S - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic [2:0]    r_state;
  logic [15:0]   r_target;
  logic [1:0]    r_digit;
  logic          r_tmr_rst;
  logic          r_rst_d;
  logic          r_tmr_stop;
  logic          r_tmr_setting;
  logic          r_alarm;
  logic [HW-1:0] r_hold;
  logic [15:0]   r_times;
  logic [15:0]   r_time_out;

  logic [2:0]    w_state_nxt;
  logic [15:0]   w_target_nxt;
  logic [1:0]    w_digit_nxt;
  logic          w_rst_nxt;
  logic          w_alarm_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [3:0]    w_sel_digit;
  logic [3:0]    w_inc_digit;
  logic          w_done_hit;
  logic          w_blank;

  assign w_sel_digit = r_target[{r_digit, 2'b00} +: 4];

  bcd_digit_inc u_digit_inc (
    .i_digit (w_sel_digit),
    .i_max   (digit_max(r_digit)),
    .o_digit (w_inc_digit)
  );

  assign w_done_hit = (r_times == r_target) || (r_time_out != '0);
  // r_times still shows the pre-clear count for two cycles after a tmr_rst pulse
  assign w_blank    = r_tmr_rst | r_rst_d;

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_digit_nxt  = r_digit;
    w_rst_nxt    = 1'b0;
    w_alarm_nxt  = r_alarm;
    w_hold_nxt   = r_hold;
    if (btn_clear) begin
      w_state_nxt = ST_IDLE;
      w_rst_nxt   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (btn_set) begin
            w_state_nxt = ST_SET;
            w_digit_nxt = DIG_M1;
          end else if (btn_start && (r_target != '0)) begin
            w_state_nxt = ST_RUN;
            w_rst_nxt   = 1'b1;
          end
        end
        ST_SET: begin
          if (btn_set) begin
            if (r_digit == DIG_S0) w_state_nxt = ST_IDLE;
            else                   w_digit_nxt = r_digit - 2'd1;
          end else if (btn_inc && !btn_start) begin
            w_target_nxt[{r_digit, 2'b00} +: 4] = w_inc_digit;
          end
        end
        ST_RUN: begin
          if (!btn_set) begin
            if (btn_start) begin
              w_state_nxt = ST_PAUSE;
            end else if (w_done_hit && !w_blank) begin
              w_state_nxt = ST_DONE;
              w_alarm_nxt = 1'b1;
              w_hold_nxt  = '0;
            end
          end
        end
        ST_PAUSE: begin
          if (!btn_set && btn_start) w_state_nxt = ST_RUN;
        end
        ST_DONE: begin
          if (btn_set || btn_start) begin
            w_state_nxt = ST_IDLE;
          end else if (sec_tick) begin
            w_hold_nxt = r_hold + HOLD_ONE;
`ifdef ALARM_BLINK_EN
            w_alarm_nxt = ~r_alarm;
`else
            w_alarm_nxt = 1'b1;
`endif
            if ((DONE_HOLD_S != 0) && (r_hold == HOLD_LAST)) w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    if (w_state_nxt != ST_DONE) begin
      w_alarm_nxt = 1'b0;
      w_hold_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge init_rst) begin
    if (!init_rst) begin
      r_state       <= ST_IDLE;
      r_target      <= TARGET_RST;
      r_digit       <= DIG_M1;
      r_tmr_rst     <= 1'b0;
      r_rst_d       <= 1'b0;
      r_tmr_stop    <= 1'b1;
      r_tmr_setting <= 1'b0;
      r_alarm       <= 1'b0;
      r_hold        <= '0;
      r_times       <= '0;
      r_time_out    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_target      <= w_target_nxt;
      r_digit       <= w_digit_nxt;
      r_tmr_rst     <= w_rst_nxt;
      r_rst_d       <= r_tmr_rst;
      r_tmr_stop    <= (w_state_nxt != ST_RUN);
      r_tmr_setting <= (w_state_nxt == ST_SET);
      r_alarm       <= w_alarm_nxt;
      r_hold        <= w_hold_nxt;
      r_times       <= times;
      r_time_out    <= time_out;
    end
  end

  assign tmr_rst     = r_tmr_rst;
  assign tmr_stop    = r_tmr_stop;
  assign tmr_setting = r_tmr_setting;
  assign target      = r_target;
  assign set_digit   = r_digit;
  assign state       = r_state;
  assign alarm       = r_alarm;

endmodule

// File: tb/tb_timer_seq_ctl.sv
// Scoreboard bench for timer_seq_ctl: expected output vectors queued per stimulus step.
module tb_timer_seq_ctl;

  localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_RUN = 3'd2, S_PAUSE = 3'd3, S_DONE = 3'd4;
  localparam logic [4:0] B_NONE = 5'b00000, B_ST = 5'b10000, B_CL = 5'b01000,
                         B_SE = 5'b00100, B_IN = 5'b00010, B_TK = 5'b00001;

  typedef struct packed {
    logic [15:0] tm;
    logic        to;
    logic [4:0]  b;
  } stim_t;

  logic        clk = 1'b0;
  logic        init_rst;
  logic        btn_start, btn_clear, btn_set, btn_inc, sec_tick;
  logic [15:0] times, time_out;
  logic        tmr_rst, tmr_stop, tmr_setting, alarm;
  logic [15:0] target;
  logic [1:0]  set_digit;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;
  logic [24:0] sb_q[$];
  logic [24:0] exp_v;
  logic [24:0] obs_v;

  timer_seq_ctl #(.DONE_HOLD_S(5), .TARGET_RST(16'h0100)) dut (
    .clk(clk), .init_rst(init_rst),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_set(btn_set), .btn_inc(btn_inc),
    .sec_tick(sec_tick), .times(times), .time_out(time_out),
    .tmr_rst(tmr_rst), .tmr_stop(tmr_stop), .tmr_setting(tmr_setting),
    .target(target), .set_digit(set_digit), .state(state), .alarm(alarm)
  );

  always #5 clk = ~clk;

  assign obs_v = {state, tmr_rst, tmr_stop, tmr_setting, alarm, set_digit, target};

  function automatic logic [24:0] pk(input logic [2:0] st, input logic rs, input logic sp,
                                     input logic sg, input logic al, input logic [1:0] dg,
                                     input logic [15:0] tg);
    return {st, rs, sp, sg, al, dg, tg};
  endfunction

  function automatic stim_t S(input logic [15:0] tm, input logic to, input logic [4:0] b);
    stim_t r;
    r.tm = tm; r.to = to; r.b = b;
    return r;
  endfunction

  task automatic drive(input stim_t s);
    @(negedge clk);
    times    = s.tm;
    time_out = s.to ? 16'hFFFF : 16'h0000;
    {btn_start, btn_clear, btn_set, btn_inc, sec_tick} = s.b;
    @(posedge clk);
    #1;
    {btn_start, btn_clear, btn_set, btn_inc, sec_tick} = '0;
  endtask

  task automatic test_reset();
    init_rst = 1'b0;
    times = '0; time_out = '0;
    {btn_start, btn_clear, btn_set, btn_inc, sec_tick} = '0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd3, 16'h0100));
    exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs_v, exp_v); end
    @(negedge clk);
    init_rst = 1'b1;
    sb_q.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd3, 16'h0100));
    drive(S(16'h0000, 0, B_NONE));
    exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs_v, exp_v); end
  endtask

  task automatic test_run_done();
    stim_t s[$]; logic [24:0] e[$];
    s.push_back(S(16'h0000, 0, B_ST));   e.push_back(pk(S_RUN,  1, 0, 0, 0, 2'd3, 16'h0100));
    s.push_back(S(16'h0000, 0, B_NONE)); e.push_back(pk(S_RUN,  0, 0, 0, 0, 2'd3, 16'h0100));
    s.push_back(S(16'h0100, 0, B_NONE)); e.push_back(pk(S_RUN,  0, 0, 0, 0, 2'd3, 16'h0100));
    s.push_back(S(16'h0100, 0, B_NONE)); e.push_back(pk(S_DONE, 0, 1, 0, 1, 2'd3, 16'h0100));
    s.push_back(S(16'h0100, 0, B_CL));   e.push_back(pk(S_IDLE, 1, 1, 0, 0, 2'd3, 16'h0100));
    s.push_back(S(16'h0000, 0, B_NONE)); e.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd3, 16'h0100));
    for (int i = 0; i < s.size(); i++) begin
      sb_q.push_back(e[i]);
      drive(s[i]);
      exp_v = sb_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL run_done[%0d] got=%h exp=%h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_set_inc();
    stim_t s[$]; logic [24:0] e[$];
    logic [3:0] m1_seq [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd3, 16'h0100));
    for (int k = 0; k < 7; k++) begin
      s.push_back(S(0, 0, B_IN)); e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd3, {m1_seq[k], 12'h100}));
    end
    s.push_back(S(0, 0, B_ST));        e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd3, 16'h1100));
    s.push_back(S(0, 0, B_SE | B_IN)); e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd2, 16'h1100));
    s.push_back(S(0, 0, B_SE));        e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd1, 16'h1100));
    s.push_back(S(0, 0, B_SE));        e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd0, 16'h1100));
    for (int k = 1; k <= 10; k++) begin
      logic [3:0] d;
      d = (k == 10) ? 4'd0 : 4'(k);
      s.push_back(S(0, 0, B_IN)); e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd0, {12'h110, d}));
    end
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd0, 16'h1100));
    for (int i = 0; i < s.size(); i++) begin
      sb_q.push_back(e[i]);
      drive(s[i]);
      exp_v = sb_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL set_inc[%0d] got=%h exp=%h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_pause();
    stim_t s[$]; logic [24:0] e[$];
    s.push_back(S(0, 0, B_ST));        e.push_back(pk(S_RUN,   1, 0, 0, 0, 2'd0, 16'h1100));
    s.push_back(S(0, 0, B_NONE));      e.push_back(pk(S_RUN,   0, 0, 0, 0, 2'd0, 16'h1100));
    s.push_back(S(0, 0, B_ST));        e.push_back(pk(S_PAUSE, 0, 1, 0, 0, 2'd0, 16'h1100));
    s.push_back(S(0, 0, B_NONE));      e.push_back(pk(S_PAUSE, 0, 1, 0, 0, 2'd0, 16'h1100));
    s.push_back(S(0, 0, B_ST));        e.push_back(pk(S_RUN,   0, 0, 0, 0, 2'd0, 16'h1100));
    s.push_back(S(0, 0, B_ST | B_CL)); e.push_back(pk(S_IDLE,  1, 1, 0, 0, 2'd0, 16'h1100));
    s.push_back(S(0, 0, B_NONE));      e.push_back(pk(S_IDLE,  0, 1, 0, 0, 2'd0, 16'h1100));
    for (int i = 0; i < s.size(); i++) begin
      sb_q.push_back(e[i]);
      drive(s[i]);
      exp_v = sb_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL pause[%0d] got=%h exp=%h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_zero_target();
    stim_t s[$]; logic [24:0] e[$];
    logic [3:0] m1_seq [5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    logic [3:0] m0_seq [9] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd3, 16'h1100));
    for (int k = 0; k < 5; k++) begin
      s.push_back(S(0, 0, B_IN)); e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd3, {m1_seq[k], 12'h100}));
    end
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd2, 16'h0100));
    for (int k = 0; k < 9; k++) begin
      s.push_back(S(0, 0, B_IN)); e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd2, {4'h0, m0_seq[k], 8'h00}));
    end
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_SET,  0, 1, 1, 0, 2'd1, 16'h0000));
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_SET,  0, 1, 1, 0, 2'd0, 16'h0000));
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd0, 16'h0000));
    s.push_back(S(0, 0, B_ST)); e.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd0, 16'h0000));
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_SET,  0, 1, 1, 0, 2'd3, 16'h0000));
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_SET,  0, 1, 1, 0, 2'd2, 16'h0000));
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_SET,  0, 1, 1, 0, 2'd1, 16'h0000));
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_SET,  0, 1, 1, 0, 2'd0, 16'h0000));
    s.push_back(S(0, 0, B_IN)); e.push_back(pk(S_SET,  0, 1, 1, 0, 2'd0, 16'h0001));
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd0, 16'h0001));
    for (int i = 0; i < s.size(); i++) begin
      sb_q.push_back(e[i]);
      drive(s[i]);
      exp_v = sb_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL zero_target[%0d] got=%h exp=%h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_timeout_done_hold();
    stim_t s[$]; logic [24:0] e[$];
    logic al;
    s.push_back(S(0, 0, B_ST));   e.push_back(pk(S_RUN,  1, 0, 0, 0, 2'd0, 16'h0001));
    s.push_back(S(0, 0, B_NONE)); e.push_back(pk(S_RUN,  0, 0, 0, 0, 2'd0, 16'h0001));
    s.push_back(S(0, 1, B_NONE)); e.push_back(pk(S_RUN,  0, 0, 0, 0, 2'd0, 16'h0001));
    s.push_back(S(0, 1, B_NONE)); e.push_back(pk(S_DONE, 0, 1, 0, 1, 2'd0, 16'h0001));
    s.push_back(S(0, 0, B_NONE)); e.push_back(pk(S_DONE, 0, 1, 0, 1, 2'd0, 16'h0001));
    for (int k = 1; k <= 4; k++) begin
`ifdef ALARM_BLINK_EN
      al = (k % 2 == 0);
`else
      al = 1'b1;
`endif
      s.push_back(S(0, 0, B_TK)); e.push_back(pk(S_DONE, 0, 1, 0, al, 2'd0, 16'h0001));
    end
    s.push_back(S(0, 0, B_TK));   e.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd0, 16'h0001));
    s.push_back(S(0, 0, B_TK));   e.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd0, 16'h0001));
    s.push_back(S(0, 0, B_ST));   e.push_back(pk(S_RUN,  1, 0, 0, 0, 2'd0, 16'h0001));
    s.push_back(S(0, 0, B_NONE)); e.push_back(pk(S_RUN,  0, 0, 0, 0, 2'd0, 16'h0001));
    s.push_back(S(0, 1, B_NONE)); e.push_back(pk(S_RUN,  0, 0, 0, 0, 2'd0, 16'h0001));
    s.push_back(S(0, 1, B_NONE)); e.push_back(pk(S_DONE, 0, 1, 0, 1, 2'd0, 16'h0001));
    s.push_back(S(0, 0, B_SE));   e.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd0, 16'h0001));
    for (int i = 0; i < s.size(); i++) begin
      sb_q.push_back(e[i]);
      drive(s[i]);
      exp_v = sb_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL timeout_hold[%0d] got=%h exp=%h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_reset_mid_set();
    stim_t s[$]; logic [24:0] e[$];
    s.push_back(S(0, 0, B_SE)); e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd3, 16'h0001));
    s.push_back(S(0, 0, B_IN)); e.push_back(pk(S_SET, 0, 1, 1, 0, 2'd3, 16'h1001));
    for (int i = 0; i < s.size(); i++) begin
      sb_q.push_back(e[i]);
      drive(s[i]);
      exp_v = sb_q.pop_front(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL mid_set[%0d] got=%h exp=%h", i, obs_v, exp_v); end
    end
    @(negedge clk);
    #2;
    init_rst = 1'b0;
    #1;
    sb_q.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd3, 16'h0100));
    exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL async_reset got=%h exp=%h", obs_v, exp_v); end
    @(negedge clk);
    init_rst = 1'b1;
    sb_q.push_back(pk(S_IDLE, 0, 1, 0, 0, 2'd3, 16'h0100));
    drive(S(0, 0, B_NONE));
    exp_v = sb_q.pop_front(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL after_reset got=%h exp=%h", obs_v, exp_v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_run_done();
    test_set_inc();
    test_pause();
    test_zero_target();
    test_timeout_done_hold();
    test_reset_mid_set();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
